// File: rtl/tt_um_jimktrains_vslc_mtimer.sv
// Multi-channel two-phase timer with a shared prescaler.
// Each channel emits A-high / B-low waveforms, continuous or one-shot.
module tt_um_jimktrains_vslc_mtimer #(
  parameter int WIDTH      = 10,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS*WIDTH-1:0] period_a,
  input  logic [CHANNELS*WIDTH-1:0] period_b,
  input  logic [PRESCALE_W-1:0]     prescale,
  output logic [CHANNELS-1:0]       timer_out,
  output logic [CHANNELS-1:0]       wrap_o,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*WIDTH-1:0] counter_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PH_A  = 2'd1,
    PH_B  = 2'd2,
    DONE  = 2'd3
  } state_e;

  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic                  any_en;
  logic                  tick;

  // Shared divider: counts only while some channel runs.
  always_comb begin
    any_en = |enable;
    tick   = any_en && (ps_q >= prescale);
    ps_d   = ps_q + 1'b1;
    if (!any_en || tick) ps_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    state_e             st_q, st_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   pa, pb;

    assign pa = period_a[g*WIDTH +: WIDTH];
    assign pb = period_b[g*WIDTH +: WIDTH];

    // Channel next-state: enable low wins, periods compared live.
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      wrap_d = 1'b0;
      done_d = 1'b0;
      if (!enable[g]) begin
        st_d  = IDLE;
        cnt_d = '0;
        out_d = 1'b0;
      end else begin
        unique case (st_q)
          IDLE: begin
            st_d  = PH_A;
            cnt_d = '0;
            out_d = 1'b1;
          end
          PH_A: begin
            if (tick) begin
              if (cnt_q >= pa) begin
                st_d  = PH_B;
                cnt_d = '0;
                out_d = 1'b0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          PH_B: begin
            if (tick) begin
              if (cnt_q >= pb) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
                if (oneshot[g]) begin
                  st_d   = DONE;
                  out_d  = 1'b0;
                  done_d = 1'b1;
                end else begin
                  st_d  = PH_A;
                  out_d = 1'b1;
                end
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          DONE: begin
            cnt_d  = '0;
            out_d  = 1'b0;
            done_d = 1'b1;
          end
          default: begin
            st_d  = IDLE;
            cnt_d = '0;
            out_d = 1'b0;
          end
        endcase
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        out_q  <= 1'b0;
        wrap_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        wrap_q <= wrap_d;
        done_q <= done_d;
      end
    end

    assign timer_out[g]                 = out_q;
    assign wrap_o[g]                    = wrap_q;
    assign done[g]                      = done_q;
    assign counter_o[g*WIDTH +: WIDTH]  = cnt_q;
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_mtimer.sv
// Randomized bench for the multi-channel timer.
// A phase-level reference model predicts every output each clock.
module tb_tt_um_jimktrains_vslc_mtimer;
  localparam int W  = 4;
  localparam int CH = 4;
  localparam int PW = 8;

  localparam int S_IDLE = 0;
  localparam int S_A    = 1;
  localparam int S_B    = 2;
  localparam int S_DONE = 3;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   oneshot;
  logic [CH*W-1:0] period_a;
  logic [CH*W-1:0] period_b;
  logic [PW-1:0]   prescale;
  logic [CH-1:0]   timer_out;
  logic [CH-1:0]   wrap_o;
  logic [CH-1:0]   done;
  logic [CH*W-1:0] counter_o;

  int n_chk;
  int n_err;

  int m_ps;
  int m_ph   [CH];
  int m_cnt  [CH];
  bit m_wrap [CH];

  tt_um_jimktrains_vslc_mtimer #(
    .WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enable(enable), .oneshot(oneshot),
    .period_a(period_a), .period_b(period_b),
    .prescale(prescale),
    .timer_out(timer_out), .wrap_o(wrap_o),
    .done(done), .counter_o(counter_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ps = 0;
    for (int i = 0; i < CH; i++) begin
      m_ph[i] = S_IDLE;
      m_cnt[i] = 0;
      m_wrap[i] = 0;
    end
  endfunction

  // One clock of the timer rules, using the inputs about to be sampled.
  function automatic void model_step();
    bit any;
    bit tk;
    int pa;
    int pb;
    any = (enable != '0);
    tk  = any && (m_ps >= int'(prescale));
    if (!any || tk) m_ps = 0;
    else m_ps = m_ps + 1;
    for (int i = 0; i < CH; i++) begin
      pa = int'(period_a[i*W +: W]);
      pb = int'(period_b[i*W +: W]);
      m_wrap[i] = 0;
      if (!enable[i]) begin
        m_ph[i] = S_IDLE;
        m_cnt[i] = 0;
      end else if (m_ph[i] == S_IDLE) begin
        m_ph[i] = S_A;
        m_cnt[i] = 0;
      end else if (m_ph[i] == S_A && tk) begin
        if (m_cnt[i] >= pa) begin
          m_ph[i] = S_B;
          m_cnt[i] = 0;
        end else m_cnt[i]++;
      end else if (m_ph[i] == S_B && tk) begin
        if (m_cnt[i] >= pb) begin
          m_wrap[i] = 1;
          m_cnt[i] = 0;
          m_ph[i] = oneshot[i] ? S_DONE : S_A;
        end else m_cnt[i]++;
      end
    end
  endfunction

  task automatic compare();
    logic [CH-1:0]   e_out, e_wrap, e_done;
    logic [CH*W-1:0] e_cnt;
    for (int i = 0; i < CH; i++) begin
      e_out[i]  = (m_ph[i] == S_A);
      e_wrap[i] = m_wrap[i];
      e_done[i] = (m_ph[i] == S_DONE);
      e_cnt[i*W +: W] = W'(m_cnt[i]);
    end
    chk("timer_out", 64'(timer_out), 64'(e_out));
    chk("wrap_o",    64'(wrap_o),    64'(e_wrap));
    chk("done",      64'(done),      64'(e_done));
    chk("counter_o", 64'(counter_o), 64'(e_cnt));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"},  64'(timer_out), 64'd0);
    chk({tag, "_wrap"}, 64'(wrap_o),    64'd0);
    chk({tag, "_done"}, 64'(done),      64'd0);
    chk({tag, "_cnt"},  64'(counter_o), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_pa(input int ch, input int v);
    period_a[ch*W +: W] = W'(v);
  endtask

  task automatic set_pb(input int ch, input int v);
    period_b[ch*W +: W] = W'(v);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    enable = '0;
    oneshot = '0;
    period_a = '0;
    period_b = '0;
    prescale = '0;
    model_reset();
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 high / 2 low with a wrap every fifth clock.
    set_pa(0, 2);
    set_pb(0, 1);
    enable = 4'b0001;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("p30_out", 64'(timer_out[0]), 64'((k % 5) < 3));
      chk("p30_wrap", 64'(wrap_o[0]), 64'(k > 0 && (k % 5) == 0));
    end
    enable = '0;
    step();

    // Prescale 3 with zero periods: counter never leaves zero.
    prescale = 8'd3;
    set_pa(0, 0);
    set_pb(0, 0);
    enable = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("p31_cnt", 64'(counter_o[W-1:0]), 64'd0);
    end
    enable = '0;
    step();

    // One-shot: 2 high, 2 low, one wrap, then DONE.
    prescale = 8'd0;
    set_pa(0, 1);
    set_pb(0, 1);
    oneshot = 4'b0001;
    enable = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("p32_out", 64'(timer_out[0]), 64'(k < 2));
      chk("p32_wrap", 64'(wrap_o[0]), 64'(k == 4));
      chk("p32_done", 64'(done[0]), 64'(k >= 4));
    end
    enable = '0;
    step();
    chk("p32_clr", 64'(done[0]), 64'd0);
    oneshot = '0;

    // Lowering period_a below the counter ends PHASE_A next tick.
    set_pa(0, 10);
    enable = 4'b0001;
    for (int k = 0; k < 8; k++) step();
    chk("p33_cnt7", 64'(counter_o[W-1:0]), 64'd7);
    set_pa(0, 3);
    step();
    chk("p33_out", 64'(timer_out[0]), 64'd0);
    chk("p33_cnt", 64'(counter_o[W-1:0]), 64'd0);

    // Reset mid-PHASE_B, then drop one channel mid-PHASE_A.
    set_pb(0, 8);
    for (int k = 0; k < 3; k++) step();
    do_reset("p34_rst");
    set_pa(1, 9);
    enable = 4'b0011;
    for (int k = 0; k < 4; k++) step();
    enable = 4'b0001;
    step();
    chk("p34_out1", 64'(timer_out[1]), 64'd0);
    chk("p34_wrap1", 64'(wrap_o[1]), 64'd0);
    chk("p34_cnt1", 64'(counter_o[2*W-1:W]), 64'd0);

    // Independent channels, one with all-ones period (16-tick phase).
    set_pa(0, 1); set_pb(0, 2);
    set_pa(1, 3); set_pb(1, 0);
    set_pa(2, 5); set_pb(2, 4);
    set_pa(3, 15); set_pb(3, 15);
    enable = 4'b1111;
    for (int k = 0; k < 70; k++) step();

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0)
        enable[$urandom_range(0, CH-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0)
        oneshot[$urandom_range(0, CH-1)] ^= 1'b1;
      if ($urandom_range(0, 11) == 0)
        set_pa($urandom_range(0, CH-1),
               ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6));
      if ($urandom_range(0, 11) == 0)
        set_pb($urandom_range(0, CH-1),
               ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0)
        prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0)
        do_reset("rnd_rst");
      else
        step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
